// File: rtl/register_file_sb.sv
// Multi-port register file with combinational reads, optional write bypass,
// optional hardwired zero register and a busy-bit scoreboard with a live count.

module rf_read_port #(
   parameter int WIDTH          = 32,
   parameter int ADDRESS_LENGTH = 5,
   parameter int SIZE           = 1 << ADDRESS_LENGTH,
   parameter int WRITE_PORTS    = 2,
   parameter int BYPASS         = 1,
   parameter int ZERO_REG       = 1
) (
   input  logic [ADDRESS_LENGTH-1:0]                   ra,
   input  logic [SIZE-1:0][WIDTH-1:0]                  regs,
   input  logic [SIZE-1:0]                             busy,
   input  logic [WRITE_PORTS-1:0]                      weff,
   input  logic [WRITE_PORTS-1:0][ADDRESS_LENGTH-1:0]  wa,
   input  logic [WRITE_PORTS-1:0][WIDTH-1:0]           wd,
   output logic [WIDTH-1:0]                            rd,
   output logic                                        rd_busy
);

   always_comb begin
      rd      = '0;
      rd_busy = 1'b0;
      if (int'(ra) < SIZE) begin
         rd      = regs[ra];
         rd_busy = busy[ra];
      end
      // ascending scan so the highest-index matching write port is forwarded
      if (BYPASS != 0) begin
         for (int j = 0; j < WRITE_PORTS; j++) begin
            if (weff[j] && wa[j] == ra) begin
               rd      = wd[j];
               rd_busy = 1'b0;
            end
         end
      end
      if (ZERO_REG != 0 && ra == '0) begin
         rd      = '0;
         rd_busy = 1'b0;
      end
   end

endmodule

module register_file_sb #(
   parameter int WIDTH          = 32,
   parameter int ADDRESS_LENGTH = 5,
   parameter int SIZE           = 1 << ADDRESS_LENGTH,
   parameter int READ_PORTS     = 2,
   parameter int WRITE_PORTS    = 2,
   parameter int BYPASS         = 1,
   parameter int ZERO_REG       = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [READ_PORTS*ADDRESS_LENGTH-1:0]   ra,
   output logic [READ_PORTS*WIDTH-1:0]            rd,
   output logic [READ_PORTS-1:0]                  rd_busy,
   input  logic [WRITE_PORTS-1:0]                 we,
   input  logic [WRITE_PORTS*ADDRESS_LENGTH-1:0]  wa,
   input  logic [WRITE_PORTS*WIDTH-1:0]           wd,
   input  logic                                   rsv_en,
   input  logic [ADDRESS_LENGTH-1:0]              rsv_addr,
   input  logic                                   flush,
   output logic [ADDRESS_LENGTH:0]                busy_count
);

   localparam int CW = ADDRESS_LENGTH + 1;

   logic [SIZE-1:0][WIDTH-1:0]                  regs;
   logic [SIZE-1:0]                             busy, busy_nxt;
   logic [WRITE_PORTS-1:0][ADDRESS_LENGTH-1:0]  wa_v;
   logic [WRITE_PORTS-1:0][WIDTH-1:0]           wd_v;
   logic [WRITE_PORTS-1:0]                      weff;
   logic [CW-1:0]                               rise, fall;

   assign wa_v = wa;
   assign wd_v = wd;

   // rst also masks writes so nothing is forwarded to reads while in reset
   always_comb begin
      weff = '0;
      for (int j = 0; j < WRITE_PORTS; j++)
         weff[j] = we[j] && !rst && !(ZERO_REG != 0 && wa_v[j] == '0);
   end

   always_comb begin
      busy_nxt = flush ? '0 : busy;
      for (int r = 0; r < SIZE; r++) begin
         for (int j = 0; j < WRITE_PORTS; j++)
            if (weff[j] && int'(wa_v[j]) == r) busy_nxt[r] = 1'b0;
         if (rsv_en && int'(rsv_addr) == r && !(ZERO_REG != 0 && r == 0))
            busy_nxt[r] = 1'b1;
      end
   end

   // count tracks the exact set/clear delta of this edge, so it cannot wrap
   assign rise = CW'($countones(busy_nxt & ~busy));
   assign fall = CW'($countones(busy & ~busy_nxt));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs       <= '0;
         busy       <= '0;
         busy_count <= '0;
      end else begin
         for (int r = 0; r < SIZE; r++)
            for (int j = 0; j < WRITE_PORTS; j++)
               if (weff[j] && int'(wa_v[j]) == r) regs[r] <= wd_v[j];
         busy       <= busy_nxt;
         busy_count <= busy_count + rise - fall;
      end
   end

   for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
      rf_read_port #(
         .WIDTH(WIDTH), .ADDRESS_LENGTH(ADDRESS_LENGTH), .SIZE(SIZE),
         .WRITE_PORTS(WRITE_PORTS), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
      ) u_rd (
         .ra      (ra[i*ADDRESS_LENGTH +: ADDRESS_LENGTH]),
         .regs    (regs),
         .busy    (busy),
         .weff    (weff),
         .wa      (wa_v),
         .wd      (wd_v),
         .rd      (rd[i*WIDTH +: WIDTH]),
         .rd_busy (rd_busy[i])
      );
   end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed and model-checked stimulus for register_file_sb, with a bypass and a
// non-bypass instance sharing the same inputs.

module tb_register_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  ra;
   logic [63:0] rd, rd_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic [1:0]  we;
   logic [9:0]  wa;
   logic [63:0] wd;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        flush;
   logic [5:0]  busy_count, busy_count_nb;

   int total = 0;
   int bad   = 0;

   logic [31:0] mregs [32];
   logic [31:0] mbusy;
   int          mcnt;

   always #5 clk = ~clk;

   register_file_sb dut (
      .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .flush(flush), .busy_count(busy_count)
   );

   register_file_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .ra(ra), .rd(rd_nb), .rd_busy(rd_busy_nb),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .flush(flush), .busy_count(busy_count_nb)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < 32; a++) mregs[a] = '0;
      mbusy = '0;
      mcnt  = 0;
   endtask

   // advances one rising edge and applies the same inputs to the reference model
   task automatic tick();
      @(posedge clk);
      for (int j = 0; j < 2; j++)
         if (we[j] && wa[j*5 +: 5] != 5'd0) mregs[wa[j*5 +: 5]] = wd[j*32 +: 32];
      if (flush) mbusy = '0;
      for (int j = 0; j < 2; j++)
         if (we[j] && wa[j*5 +: 5] != 5'd0) mbusy[wa[j*5 +: 5]] = 1'b0;
      if (rsv_en && rsv_addr != 5'd0) mbusy[rsv_addr] = 1'b1;
      mcnt = $countones(mbusy);
      #1;
   endtask

   function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
      logic [31:0] v;
      v = mregs[a];
      if (byp)
         for (int j = 0; j < 2; j++)
            if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
      if (a == 5'd0) v = '0;
      return v;
   endfunction

   function automatic logic m_rb(input logic [4:0] a, input bit byp);
      logic b;
      b = mbusy[a];
      if (byp)
         for (int j = 0; j < 2; j++)
            if (we[j] && wa[j*5 +: 5] == a && a != 5'd0) b = 1'b0;
      if (a == 5'd0) b = 1'b0;
      return b;
   endfunction

   initial begin
      rst = 1'b1; ra = '0; we = '0; wa = '0; wd = '0;
      rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
      model_reset();

      // reset state on every address
      #2;
      chk("reset_count", 64'(busy_count), 64'd0);
      for (int a = 0; a < 32; a++) begin
         ra = {5'(a), 5'(a)};
         #1;
         chk("reset_rd", rd, 64'd0);
         chk("reset_busy", 64'(rd_busy), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // same-cycle write/read of addr 5
      we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
      #1;
      chk("bypass_same_cycle", 64'(rd[31:0]), 64'hDEADBEEF);
      chk("nobypass_same_cycle", 64'(rd_nb[31:0]), 64'd0);
      tick();
      we = '0;
      #1;
      chk("nobypass_next_cycle", 64'(rd_nb[31:0]), 64'hDEADBEEF);
      chk("bypass_next_cycle", 64'(rd[31:0]), 64'hDEADBEEF);

      // both ports to addr 7: port 1 wins
      we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11}; ra = {5'd0, 5'd7};
      #1;
      chk("dual_write_bypass", 64'(rd[31:0]), 64'h22);
      tick();
      we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFFFFFF}; ra = {5'd7, 5'd0};
      #1;
      chk("dual_write_stored", 64'(rd_nb[63:32]), 64'h22);
      chk("zero_bypass", 64'(rd[31:0]), 64'd0);
      tick();
      we = '0;
      #1;
      chk("zero_after_write", 64'(rd[31:0]), 64'd0);
      chk("zero_after_write_nb", 64'(rd_nb[31:0]), 64'd0);

      // reserve, release, reserve+write
      rsv_en = 1'b1; rsv_addr = 5'd3; ra = {5'd0, 5'd3};
      #1;
      chk("rsv_not_yet", 64'(rd_busy[0]), 64'd0);
      tick();
      rsv_en = 1'b0;
      #1;
      chk("rsv_busy", 64'(rd_busy[0]), 64'd1);
      chk("rsv_count", 64'(busy_count), 64'd1);
      we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h33};
      #1;
      chk("release_busy_forced", 64'(rd_busy[0]), 64'd0);
      chk("release_busy_nb", 64'(rd_busy_nb[0]), 64'd1);
      tick();
      we = '0;
      #1;
      chk("release_busy", 64'(rd_busy[0]), 64'd0);
      chk("release_count", 64'(busy_count), 64'd0);
      chk("release_data", 64'(rd[31:0]), 64'h33);
      rsv_en = 1'b1; rsv_addr = 5'd3;
      tick();
      we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h44};
      tick();
      we = '0; rsv_en = 1'b0;
      #1;
      chk("wr_rsv_busy", 64'(rd_busy[0]), 64'd1);
      chk("wr_rsv_count", 64'(busy_count), 64'd1);
      chk("wr_rsv_data", 64'(rd[31:0]), 64'h44);

      // fill the scoreboard
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_count", 64'(busy_count), 64'd0);
      for (int a = 1; a < 32; a++) begin
         rsv_en = 1'b1; rsv_addr = 5'(a);
         tick();
      end
      rsv_en = 1'b0;
      #1;
      chk("full_count", 64'(busy_count), 64'd31);
      rsv_en = 1'b1; rsv_addr = 5'd0; ra = {5'd31, 5'd0};
      tick();
      #1;
      chk("rsv0_count", 64'(busy_count), 64'd31);
      chk("rsv0_busy", 64'(rd_busy), 64'b10);
      rsv_addr = 5'd5;
      tick();
      #1;
      chk("rsv_again_count", 64'(busy_count), 64'd31);
      flush = 1'b1; rsv_addr = 5'd9;
      tick();
      flush = 1'b0; rsv_en = 1'b0; ra = {5'd8, 5'd9};
      #1;
      chk("flush_rsv_count", 64'(busy_count), 64'd1);
      chk("flush_rsv_busy", 64'(rd_busy), 64'b01);
      chk("flush_rsv_count_nb", 64'(busy_count_nb), 64'd1);

      // asynchronous reset mid-cycle
      ra = {5'd9, 5'd7};
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_rd", rd, 64'd0);
      chk("async_rst_busy", 64'(rd_busy), 64'd0);
      chk("async_rst_count", 64'(busy_count), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk("post_rst_rd", rd_nb, 64'd0);

      // random stream against the reference model
      for (int c = 0; c < 3000; c++) begin
         we       = 2'($urandom);
         wa       = 10'($urandom);
         wd       = {$urandom, $urandom};
         rsv_en   = 1'($urandom);
         rsv_addr = 5'($urandom);
         flush    = ($urandom_range(0, 15) == 0);
         ra       = ($urandom_range(0, 3) == 0) ? wa : 10'($urandom);
         #1;
         for (int i = 0; i < 2; i++) begin
            chk("rand_rd", 64'(rd[i*32 +: 32]), 64'(m_rd(ra[i*5 +: 5], 1'b1)));
            chk("rand_busy", 64'(rd_busy[i]), 64'(m_rb(ra[i*5 +: 5], 1'b1)));
            chk("rand_rd_nb", 64'(rd_nb[i*32 +: 32]), 64'(m_rd(ra[i*5 +: 5], 1'b0)));
            chk("rand_busy_nb", 64'(rd_busy_nb[i]), 64'(m_rb(ra[i*5 +: 5], 1'b0)));
         end
         chk("rand_count", 64'(busy_count), 64'(mcnt));
         tick();
      end
      #1;
      chk("final_count", 64'(busy_count), 64'(mcnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
